// File: rtl/img_xform_if.sv
// img_xform_if: frame-buffer access and start/busy/done handshake for the transform engine
interface img_xform_if #(
  parameter int ADDR_W = 6,
  parameter int CH_W   = 8
);
  localparam int PW = 3 * CH_W;
  logic              start;
  logic [1:0]        mode;
  logic [PW-1:0]     in_pix;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic              out_we;
  logic [PW-1:0]     out_pix;
  logic              busy;
  logic              done;
  modport master(input start, mode, in_pix, output row, col, out_we, out_pix, busy, done);
  modport slave(output start, mode, in_pix, input row, col, out_we, out_pix, busy, done);
endinterface

// File: rtl/img_xform_engine.sv
// img_xform_engine: in-place vertical/horizontal flip or grayscale over a square frame buffer
module img_xform_engine #(
  parameter int ADDR_W    = 6,
  parameter int CH_W      = 8,
  parameter int GRAY_REPL = 0
) (
  input logic clk,
  input logic rst,
  img_xform_if.master bus
);
  localparam int PW = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [ADDR_W-1:0] HALF_LAST = LAST >> 1;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_B, WR_A, G_RD, G_WR, FIN} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] o, n, nxt_o, nxt_n, a_row, a_col, b_row, b_col, nxt_row, nxt_col;
  logic hf, nxt_hf, nxt_we;
  logic [PW-1:0] buf_a, buf_b, nxt_pix, gray;
  logic [CH_W-1:0] r_c, g_c, b_c, mn, mx, avg;
  assign {r_c, g_c, b_c} = bus.in_pix;
  assign bus.busy = !(state == IDLE || state == FIN);
  assign bus.done = state == FIN;
  // gray value of the pixel currently on in_pix: midpoint of its smallest and largest channel
  always_comb begin
    mn = r_c < g_c ? r_c : g_c;
    mn = b_c < mn ? b_c : mn;
    mx = r_c > g_c ? r_c : g_c;
    mx = b_c > mx ? b_c : mx;
    avg = CH_W'(({1'b0, mn} + {1'b0, mx}) >> 1);
    gray = GRAY_REPL != 0 ? {avg, avg, avg} : {{CH_W{1'b0}}, avg, {CH_W{1'b0}}};
  end
  // sequencing: outer counter o, inner counter n; flips walk half the inner range
  always_comb begin
    nxt = state;
    nxt_o = o;
    nxt_n = n;
    nxt_hf = hf;
    case (state)
      IDLE: if (bus.start) begin
        nxt_hf = bus.mode[0];
        nxt_o = '0;
        nxt_n = '0;
        nxt = bus.mode == 2'd3 ? FIN : bus.mode == 2'd2 ? G_RD : RD_A;
      end
      RD_A: nxt = RD_B;
      RD_B: nxt = WR_B;
      WR_B: nxt = WR_A;
      WR_A: begin
        nxt = (o == LAST && n == HALF_LAST) ? FIN : RD_A;
        nxt_n = n == HALF_LAST ? '0 : n + 1'b1;
        nxt_o = n == HALF_LAST ? o + 1'b1 : o;
      end
      G_RD: nxt = G_WR;
      G_WR: begin
        nxt = (o == LAST && n == LAST) ? FIN : G_RD;
        nxt_n = n + 1'b1;
        nxt_o = n == LAST ? o + 1'b1 : o;
      end
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // registered buffer-side outputs are derived from the state being entered
  always_comb begin
    a_row = hf == 1'b1 && nxt != IDLE ? nxt_o : nxt_n;
    a_row = nxt_hf ? nxt_o : nxt_n;
    a_col = nxt_hf ? nxt_n : nxt_o;
    b_row = nxt_hf ? nxt_o : ~nxt_n;
    b_col = nxt_hf ? ~nxt_n : nxt_o;
    nxt_row = (nxt == RD_B || nxt == WR_B) ? b_row :
              (nxt == RD_A || nxt == WR_A || nxt == G_RD || nxt == G_WR) ? a_row : '0;
    nxt_col = (nxt == RD_B || nxt == WR_B) ? b_col :
              (nxt == RD_A || nxt == WR_A || nxt == G_RD || nxt == G_WR) ? a_col : '0;
    nxt_we = nxt == WR_B || nxt == WR_A || nxt == G_WR;
    nxt_pix = nxt == WR_B ? buf_a : nxt == WR_A ? buf_b : nxt == G_WR ? gray : bus.out_pix;
  end
  // state, counters, pixel buffers and buffer-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      o <= '0;
      n <= '0;
      hf <= 1'b0;
      buf_a <= '0;
      buf_b <= '0;
      bus.row <= '0;
      bus.col <= '0;
      bus.out_we <= 1'b0;
      bus.out_pix <= '0;
    end else begin
      state <= nxt;
      o <= nxt_o;
      n <= nxt_n;
      hf <= nxt_hf;
      buf_a <= state == RD_A ? bus.in_pix : buf_a;
      buf_b <= state == RD_B ? bus.in_pix : buf_b;
      bus.row <= nxt_row;
      bus.col <= nxt_col;
      bus.out_we <= nxt_we;
      bus.out_pix <= nxt_pix;
    end
  end
endmodule
